ps2_host_rx: RTL and testbench
==============================

PS2_HOST_RX -- requirements
Module: ps2_host_rx

Interface
REQ-001 The block SHALL have parameter FILTER_LEN, default 8, meaning the number of consecutive identical synchronized ps2_clk samples needed to accept a level change.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 20000, meaning the maximum number of clk cycles between falling edges inside a frame.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  system clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ps2_clk_in  in  1  PS/2 clock line from the user_io emulation (asynchronous to clk).
REQ-007 ps2_data_in  in  1  PS/2 data line (asynchronous to clk).
REQ-008 rx_data  out  8  last received byte.
REQ-009 rx_valid  out  1  one-cycle pulse when rx_data is updated.
REQ-010 rx_ext  out  1  E0 prefix preceded rx_data (valid with rx_valid).
REQ-011 rx_release  out  1  F0 prefix preceded rx_data (valid with rx_valid).
REQ-012 rx_err  out  1  one-cycle frame-error pulse.
REQ-013 rx_err_code  out  2  error cause, valid with rx_err: 01 parity, 10 stop bit, 11 timeout.

Function
REQ-014 Both PS/2 inputs SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Filtered clock SHALL change level only after FILTER_LEN consecutive equal synchronized samples; shorter glitches SHALL be ignored.
REQ-016 A falling edge of the filtered clock SHALL be the only sampling event; the synchronized data value in that cycle is the sampled bit.
REQ-017 State IDLE: sampled 0 -> DATA with bit counter 0 and parity accumulator cleared; sampled 1 -> remain IDLE with no output.
REQ-018 State DATA: shift sampled bit in LSB-first; after the 8th bit -> PARITY.
REQ-019 State PARITY: store sampled bit -> STOP.
REQ-020 State STOP: if data bits plus parity bit contain an odd number of ones and the stop bit is 1, the byte SHALL be accepted; otherwise rx_err pulses with code 01 (parity fails; has priority) or 10 (stop bit 0 only); always -> IDLE.
REQ-021 An accepted byte SHALL produce rx_valid exactly one clk cycle after the stop-bit sampling cycle; rx_data, rx_ext, and rx_release SHALL hold until the next rx_valid.
REQ-022 A watchdog SHALL clear on every sampling event and count in non-IDLE states; on reaching TIMEOUT_CYCLES, it SHALL force IDLE and pulse rx_err with code 11.
REQ-023 rx_valid and rx_err SHALL never be asserted in the same cycle.
REQ-024 A falling edge coinciding with a timeout SHALL be discarded; the timeout wins.

Reset
REQ-025 reset SHALL force IDLE and clear synchronizers (to 1), filter (to high), watchdog, bit counter, and prefix flags.
REQ-026 Reset values SHALL be: rx_data=00, rx_valid=0, rx_ext=0, rx_release=0, rx_err=0, rx_err_code=00.
REQ-027 reset mid-frame SHALL discard the partial frame without any rx_valid or rx_err pulse.

Configuration
REQ-028 With macro PS2_RX_PREFIX_DECODE_EN defined, accepted E0/F0 bytes SHALL set pending ext/release flags and SHALL NOT pulse rx_valid.
REQ-029 With PS2_RX_PREFIX_DECODE_EN defined, the next accepted non-prefix byte SHALL be emitted with those flags, which then clear; any rx_err also clears them.
REQ-030 Without PS2_RX_PREFIX_DECODE_EN, every accepted byte including E0/F0 SHALL pulse rx_valid, and rx_ext and rx_release SHALL be constant 0.

Verification
REQ-031 Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one rx_valid, rx_data=1C, ext=0, release=0, no rx_err.
REQ-032 Frame 0x1C with parity 1 -> rx_err with code 01, no rx_valid, rx_data unchanged.
REQ-033 Macro defined, frames E0, F0, 75 -> single rx_valid, rx_data=75, ext=1, release=1; next frame 29 -> ext=0, release=0.
REQ-034 Start bit plus 3 data bits, then clock held high -> rx_err code 11 exactly TIMEOUT_CYCLES after the last edge; a following clean 0x29 frame is received correctly.
REQ-035 A 3-cycle low glitch on ps2_clk_in (FILTER_LEN=8) in IDLE and mid-frame -> no state change; the surrounding 0x5A frame is received intact.
REQ-036 reset asserted after the 4th data bit, then a clean 0x12 frame -> no pulse for the partial frame, then rx_valid with rx_data=12.

Source files
------------

// File: rtl/ps2_host_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_rx_if
// Description : Bundle of the PS/2 receive-side signals.
//               The PS/2 lines enter the receiver and the decoded byte stream
//               leaves it.
//                 master - receiver side: samples the PS/2 lines and drives
//                          the rx_* result signals.
//                 slave  - environment side: drives the PS/2 lines and
//                          observes the rx_* result signals.
//               Signals:
//                 ps2_clk_in  (1) PS/2 clock line, asynchronous to clk
//                 ps2_data_in (1) PS/2 data line, asynchronous to clk
//                 rx_data     (8) last received byte
//                 rx_valid    (1) one-cycle pulse when rx_data updates
//                 rx_ext      (1) E0 prefix preceded rx_data
//                 rx_release  (1) F0 prefix preceded rx_data
//                 rx_err      (1) one-cycle frame-error pulse
//                 rx_err_code (2) 01 parity, 10 stop bit, 11 timeout
// Revision    : 1.0 - initial release
// ============================================================================
interface ps2_host_rx_if;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ext;
    logic       rx_release;
    logic       rx_err;
    logic [1:0] rx_err_code;

    modport master (
        input  ps2_clk_in,
        input  ps2_data_in,
        output rx_data,
        output rx_valid,
        output rx_ext,
        output rx_release,
        output rx_err,
        output rx_err_code
    );

    modport slave (
        output ps2_clk_in,
        output ps2_data_in,
        input  rx_data,
        input  rx_valid,
        input  rx_ext,
        input  rx_release,
        input  rx_err,
        input  rx_err_code
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_host_rx
// Description : PS/2 host-side frame receiver. Synchronizes and glitch-filters
//               the PS/2 clock, samples data on filtered falling edges,
//               checks odd parity and stop bit, and guards each frame with a
//               watchdog.
//               Optional macro PS2_RX_PREFIX_DECODE_EN: E0/F0 prefix bytes
//               are absorbed into pending flags and reported on rx_ext /
//               rx_release alongside the following byte.
// Ports       : clk   (in)  system clock, rising edge
//               reset (in)  synchronous active-high reset
//               bus   (ps2_host_rx_if.master) PS/2 inputs and rx_* outputs
// Parameters  : FILTER_LEN     consecutive equal samples to accept a level
//               TIMEOUT_CYCLES max clk cycles between edges inside a frame
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_host_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                 clk,
    input  logic                 reset,
    ps2_host_rx_if.master        bus
);
    localparam int c_filt_w = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_wd_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILTER_LEN - 1);
    localparam logic [c_wd_w-1:0]   c_wd_last   = c_wd_w'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
    logic                dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
    logic                filt_q, filt_d;
    logic [c_filt_w-1:0] filt_cnt_q, filt_cnt_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shift_q, shift_d;
    logic                par_q, par_d;
    logic [c_wd_w-1:0]   wd_q, wd_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_ext_q, rx_ext_d;
    logic                rx_release_q, rx_release_d;
    logic                rx_err_q, rx_err_d;
    logic [1:0]          rx_err_code_q, rx_err_code_d;
    logic                ext_pend_q, ext_pend_d;
    logic                rel_pend_q, rel_pend_d;
    logic                fall;
    logic                timeout;

    always_comb begin
        // two-flop synchronizers
        clk_s1_d = bus.ps2_clk_in;
        clk_s2_d = clk_s1_q;
        dat_s1_d = bus.ps2_data_in;
        dat_s2_d = dat_s1_q;

        // Level filter: the run counter only advances while the synchronized
        // clock disagrees with the filtered level; any agreeing sample restarts it.
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (filt_cnt_q == c_filt_last) begin
                filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        fall    = filt_q & ~filt_d;
        timeout = (state_q != ST_IDLE) && (wd_q == c_wd_last);

        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_d         = par_q;
        wd_d          = (state_q == ST_IDLE) ? '0 : wd_q + 1'b1;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_ext_d      = rx_ext_q;
        rx_release_d  = rx_release_q;
        rx_err_d      = 1'b0;
        rx_err_code_d = rx_err_code_q;
        ext_pend_d    = ext_pend_q;
        rel_pend_d    = rel_pend_q;

        // Timeout is checked first so a coincident sampling edge is dropped.
        if (timeout) begin
            state_d       = ST_IDLE;
            wd_d          = '0;
            rx_err_d      = 1'b1;
            rx_err_code_d = 2'b11;
            ext_pend_d    = 1'b0;
            rel_pend_d    = 1'b0;
        end else if (fall) begin
            wd_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        par_d     = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    par_d   = par_q ^ dat_s2_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    // par_q becomes 1 when data plus parity hold an odd count of ones
                    par_d   = par_q ^ dat_s2_q;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!par_q) begin
                        rx_err_d      = 1'b1;
                        rx_err_code_d = 2'b01;
                        ext_pend_d    = 1'b0;
                        rel_pend_d    = 1'b0;
                    end else if (!dat_s2_q) begin
                        rx_err_d      = 1'b1;
                        rx_err_code_d = 2'b10;
                        ext_pend_d    = 1'b0;
                        rel_pend_d    = 1'b0;
                    end else begin
`ifdef PS2_RX_PREFIX_DECODE_EN
                        if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else if (shift_q == 8'hF0) begin
                            rel_pend_d = 1'b1;
                        end else begin
                            rx_data_d    = shift_q;
                            rx_valid_d   = 1'b1;
                            rx_ext_d     = ext_pend_q;
                            rx_release_d = rel_pend_q;
                            ext_pend_d   = 1'b0;
                            rel_pend_d   = 1'b0;
                        end
`else
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            clk_s1_q      <= 1'b1;
            clk_s2_q      <= 1'b1;
            dat_s1_q      <= 1'b1;
            dat_s2_q      <= 1'b1;
            filt_q        <= 1'b1;
            filt_cnt_q    <= '0;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            par_q         <= 1'b0;
            wd_q          <= '0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_ext_q      <= 1'b0;
            rx_release_q  <= 1'b0;
            rx_err_q      <= 1'b0;
            rx_err_code_q <= 2'b00;
            ext_pend_q    <= 1'b0;
            rel_pend_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            clk_s1_q      <= clk_s1_d;
            clk_s2_q      <= clk_s2_d;
            dat_s1_q      <= dat_s1_d;
            dat_s2_q      <= dat_s2_d;
            filt_q        <= filt_d;
            filt_cnt_q    <= filt_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_q         <= par_d;
            wd_q          <= wd_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_ext_q      <= rx_ext_d;
            rx_release_q  <= rx_release_d;
            rx_err_q      <= rx_err_d;
            rx_err_code_q <= rx_err_code_d;
            ext_pend_q    <= ext_pend_d;
            rel_pend_q    <= rel_pend_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_ext      = rx_ext_q;
    assign bus.rx_release  = rx_release_q;
    assign bus.rx_err      = rx_err_q;
    assign bus.rx_err_code = rx_err_code_q;
endmodule
`default_nettype wire

// File: tb/tb_ps2_host_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_host_rx
// Description : Self-checking bench for ps2_host_rx. Drives PS/2 frames
//               (directed and random) and compares observed pulses against a
//               frame-level reference model. Build with
//               PS2_RX_PREFIX_DECODE_EN to exercise prefix decoding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_host_rx;
    localparam int FL   = 8;
    localparam int TO   = 300;
    localparam int HALF = 24;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_rx_if bus ();

    ps2_host_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- monitor ----------------
    logic [9:0] valq[$];   // {data, ext, release}
    logic [1:0] errq[$];
    int         valcyc, errcyc, both_cnt, fall_cyc;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid) begin
                valq.push_back({bus.rx_data, bus.rx_ext, bus.rx_release});
                valcyc = cyc;
            end
            if (bus.rx_err) begin
                errq.push_back(bus.rx_err_code);
                errcyc = cyc;
            end
            if (bus.rx_valid && bus.rx_err) both_cnt++;
        end
    end

    // ---------------- checking ----------------
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model state ----------------
    logic [7:0] m_data;
    logic       m_ext, m_rel, pend_e, pend_r;

    // ---------------- PS/2 driver ----------------
    task automatic drive_bit(input logic b, input bit glitch);
        @(negedge clk);
        bus.ps2_data_in = b;
        repeat (HALF / 2) @(negedge clk);
        if (glitch) begin
            bus.ps2_clk_in = 1'b0;
            repeat (3) @(negedge clk);
            bus.ps2_clk_in = 1'b1;
        end
        repeat (HALF / 2) @(negedge clk);
        bus.ps2_clk_in = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk_in = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int nbits, input int glitch_idx);
        logic [10:0] fb;
        fb = {stop, par, d, 1'b0};
        for (int i = 0; i < nbits; i++) drive_bit(fb[i], i == glitch_idx);
        repeat (4) @(negedge clk);
    endtask

    // Send one frame and compare against the frame-level rules.
    task automatic frame_and_check(input string tag, input logic [7:0] d, input logic par,
                                   input logic stop, input int glitch_idx);
        logic odd;
        int   exp_v, exp_e;
        logic [1:0] exp_code;
        valq.delete();
        errq.delete();
        send_frame(d, par, stop, 11, glitch_idx);
        odd   = ^{d, par};
        exp_v = 0;
        exp_e = 0;
        exp_code = 2'b00;
        if (odd && stop) begin
`ifdef PS2_RX_PREFIX_DECODE_EN
            if (d == 8'hE0) pend_e = 1'b1;
            else if (d == 8'hF0) pend_r = 1'b1;
            else begin
                exp_v = 1; m_data = d; m_ext = pend_e; m_rel = pend_r;
                pend_e = 1'b0; pend_r = 1'b0;
            end
`else
            exp_v = 1; m_data = d; m_ext = 1'b0; m_rel = 1'b0;
`endif
        end else begin
            exp_e = 1;
            exp_code = odd ? 2'b10 : 2'b01;
            pend_e = 1'b0;
            pend_r = 1'b0;
        end
        chk({tag, "_nvalid"}, valq.size(), exp_v);
        chk({tag, "_nerr"}, errq.size(), exp_e);
        if (exp_v == 1 && valq.size() == 1) chk({tag, "_rx"}, valq[0], {m_data, m_ext, m_rel});
        if (exp_e == 1 && errq.size() == 1) chk({tag, "_code"}, errq[0], exp_code);
        chk({tag, "_hold"}, {bus.rx_data, bus.rx_ext, bus.rx_release}, {m_data, m_ext, m_rel});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] rd;
        int kind;
        both_cnt = 0;
        bus.ps2_clk_in  = 1'b1;
        bus.ps2_data_in = 1'b1;
        reset = 1'b1;
        m_data = 8'h00; m_ext = 1'b0; m_rel = 1'b0; pend_e = 1'b0; pend_r = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_data", bus.rx_data, 8'h00);
        chk("rst_valid", bus.rx_valid, 1'b0);
        chk("rst_ext", bus.rx_ext, 1'b0);
        chk("rst_rel", bus.rx_release, 1'b0);
        chk("rst_err", bus.rx_err, 1'b0);
        chk("rst_code", bus.rx_err_code, 2'b00);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // clean 0x1C, including output latency after the stop-bit edge
        frame_and_check("f1c", 8'h1C, 1'b0, 1'b1, -1);
        chk("f1c_latency", valcyc - fall_cyc, FL + 2);

        // 0x1C with wrong parity, then with a bad stop bit
        frame_and_check("f1c_par", 8'h1C, 1'b1, 1'b1, -1);
        frame_and_check("f1c_stop", 8'h1C, 1'b0, 1'b0, -1);

`ifdef PS2_RX_PREFIX_DECODE_EN
        frame_and_check("pfx_e0", 8'hE0, 1'b0, 1'b1, -1);
        frame_and_check("pfx_f0", 8'hF0, 1'b1, 1'b1, -1);
        frame_and_check("pfx_75", 8'h75, 1'b0, 1'b1, -1);
        chk("pfx_75_flags", {bus.rx_ext, bus.rx_release}, 2'b11);
        frame_and_check("pfx_29", 8'h29, 1'b0, 1'b1, -1);
        chk("pfx_29_flags", {bus.rx_ext, bus.rx_release}, 2'b00);
`else
        frame_and_check("raw_e0", 8'hE0, 1'b0, 1'b1, -1);
        frame_and_check("raw_f0", 8'hF0, 1'b1, 1'b1, -1);
`endif

        // timeout: start bit plus three data bits, then clock idles high
        valq.delete();
        errq.delete();
        send_frame(8'h29, 1'b0, 1'b1, 4, -1);
        repeat (TO + FL + 20) @(negedge clk);
        pend_e = 1'b0; pend_r = 1'b0;
        chk("to_nerr", errq.size(), 1);
        chk("to_nvalid", valq.size(), 0);
        if (errq.size() == 1) chk("to_code", errq[0], 2'b11);
        chk("to_time", errcyc - fall_cyc, FL + TO + 2);
        frame_and_check("to_29", 8'h29, 1'b0, 1'b1, -1);

        // short low glitches in idle and mid-frame are ignored
        bus.ps2_clk_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.ps2_clk_in = 1'b1;
        repeat (20) @(negedge clk);
        frame_and_check("gl_5a", 8'h5A, 1'b1, 1'b1, 4);

        // reset after the fourth data bit, then a clean 0x12
        valq.delete();
        errq.delete();
        send_frame(8'h12, 1'b1, 1'b1, 5, -1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_data = 8'h00; m_ext = 1'b0; m_rel = 1'b0; pend_e = 1'b0; pend_r = 1'b0;
        repeat (TO + 20) @(negedge clk);
        chk("rm_nvalid", valq.size(), 0);
        chk("rm_nerr", errq.size(), 0);
        frame_and_check("rm_12", 8'h12, 1'b1, 1'b1, -1);

        // random frames, some prefixes, some with bad parity or stop bit
        for (int n = 0; n < 16; n++) begin
            rd = 8'($urandom);
            if ($urandom_range(0, 3) == 0) rd = ($urandom_range(0, 1) != 0) ? 8'hE0 : 8'hF0;
            kind = $urandom_range(0, 5);
            frame_and_check($sformatf("rnd%0d", n), rd, ~(^rd) ^ (kind == 0), kind != 1, -1);
        end

        chk("valid_err_overlap", both_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
